mem_interface: RTL

Bus-side memory access sequencer directly downstream of the CPU address register: samples the current memory address plus a request from the control unit, runs one single-beat transaction on the external memory bus with valid/ready handshake and bounded wait, and returns aligned, extended read data or an error. Sits between the datapath (address register, write-data register) and the memory/bus fabric; the control unit stalls on `req_ready`.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_interface.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access sequencer: access sizes, FSM states, error causes.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MISALIGN = 3'd1,
    ERR_SIZE     = 3'd2,
    ERR_BUS      = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } err_e;

  // Classifies a request before any bus cycle is issued.
  function automatic err_e check_req(input logic [1:0] size, input logic [1:0] off);
    err_e res;
    res = ERR_NONE;
    case (size)
      SIZE_BYTE: res = ERR_NONE;
      SIZE_HALF: res = off[0] ? ERR_MISALIGN : ERR_NONE;
      SIZE_WORD: res = (off != 2'b00) ? ERR_MISALIGN : ERR_NONE;
      default:   res = ERR_SIZE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store strobes/replicated data and load extraction/extension.
// Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        wstrb_o = 4'b0011 << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SIZE_WORD: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_sel = 8'h0;
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    rdata_o = 32'h0;
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
      SIZE_WORD: rdata_o = rdata_i;
      default:   rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_interface.sv
// Single-beat memory access sequencer: accepts one request, runs a valid/ready bus cycle with
// a bounded wait, and returns extended read data or an error as a one-cycle response pulse.
module mem_interface
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_address,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic        bus_valid_q;
  logic        resp_valid_q;
  err_e        cause_q;
  logic [31:0] rdata_q;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  err_e        req_cause;

  mem_lane_align u_align (
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rdata_i  (bus_rdata),
    .wstrb_o  (lane_wstrb),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  assign req_cause = check_req(req_size, mem_address[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= 32'h0;
      cnt_q        <= '0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      cause_q      <= ERR_NONE;
      rdata_q      <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_valid_q <= 1'b0;
          if (req_valid) begin
            addr_q   <= mem_address;
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            wdata_q  <= write_data;
            cnt_q    <= '0;
            if (req_cause != ERR_NONE) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              cause_q      <= req_cause;
              rdata_q      <= 32'h0;
            end else begin
              state_q     <= ST_ACCESS;
              bus_valid_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // A completion in the same cycle the limit is hit takes priority over the timeout.
          if (bus_ready) begin
            state_q      <= ST_RESP;
            bus_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            cause_q      <= bus_err ? ERR_BUS : ERR_NONE;
            rdata_q      <= (bus_err || write_q) ? 32'h0 : lane_rdata;
          end else if (TIMEOUT_EN && (cnt_q == LIMIT[CNT_W-1:0])) begin
            state_q      <= ST_RESP;
            bus_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            cause_q      <= ERR_TIMEOUT;
            rdata_q      <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          cause_q      <= ERR_NONE;
          rdata_q      <= 32'h0;
        end
        default: begin
          state_q      <= ST_IDLE;
          bus_valid_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          cause_q      <= ERR_NONE;
          rdata_q      <= 32'h0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q && (cause_q != ERR_NONE);
  assign resp_rdata = rdata_q;

  // Bus fields are driven only while a cycle is outstanding so the bus idles at zero.
  assign bus_valid = bus_valid_q;
  assign bus_write = bus_valid_q & write_q;
  assign bus_addr  = bus_valid_q ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wstrb = (bus_valid_q && write_q) ? lane_wstrb : 4'b0000;
  assign bus_wdata = (bus_valid_q && write_q) ? lane_wdata : 32'h0;

endmodule
